// File: rtl/data_bus_router.sv
// Purpose: routes one load/store request to one of four address-decoded slaves, returns data or error.
// Latency: mapped access M_READY two cycles after M_VALID plus slave waits; unmapped access one cycle.
// Backpressure: master holds its request until M_READY; a slave stalls via S_READY, bounded by TIMEOUT.
module data_bus_router #(
  parameter logic [31:0] BASE0   = 32'h0000_0000,
  parameter logic [31:0] BASE1   = 32'h1000_0000,
  parameter logic [31:0] BASE2   = 32'h2000_0000,
  parameter logic [31:0] BASE3   = 32'h4000_0000,
  parameter logic [31:0] MASK    = 32'hF000_0000,
  parameter logic [7:0]  TIMEOUT = 8'd255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_m_valid,
  input  logic [31:0] i_m_addr,
  input  logic        i_m_we,
  input  logic [31:0] i_m_wdata,
  input  logic [3:0]  i_m_be,
  output logic        o_m_ready,
  output logic [31:0] o_m_rdata,
  output logic        o_m_err,
  output logic [3:0]  o_s_valid,
  output logic [31:0] o_s_addr,
  output logic        o_s_we,
  output logic [31:0] o_s_wdata,
  output logic [3:0]  o_s_be,
  input  logic [3:0]  i_s_ready,
  input  logic [31:0] i_s_rdata0,
  input  logic [31:0] i_s_rdata1,
  input  logic [31:0] i_s_rdata2,
  input  logic [31:0] i_s_rdata3
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  // Counter value on the last cycle a slave is allowed to stall.
  localparam logic [7:0] TMO_LAST = TIMEOUT - 8'd1;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_sel;
  logic [31:0] r_addr;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [7:0]  r_cnt;
  logic        r_m_ready;
  logic        r_m_err;
  logic [31:0] r_m_rdata;

  logic [3:0]  w_hit;
  logic [3:0]  w_sel;
  logic        w_sel_ready;
  logic        w_timeout;
  logic [31:0] w_sel_rdata;
  logic        w_accept;

  // Region match against the incoming address; regions may overlap.
  always_comb begin
    w_hit    = '0;
    w_hit[0] = ((i_m_addr & MASK) == (BASE0 & MASK));
    w_hit[1] = ((i_m_addr & MASK) == (BASE1 & MASK));
    w_hit[2] = ((i_m_addr & MASK) == (BASE2 & MASK));
    w_hit[3] = ((i_m_addr & MASK) == (BASE3 & MASK));
  end

  // Priority encode the hits to a one-hot select, lowest region index wins.
  always_comb begin
    w_sel = 4'b0000;
    if (w_hit[0])      w_sel = 4'b0001;
    else if (w_hit[1]) w_sel = 4'b0010;
    else if (w_hit[2]) w_sel = 4'b0100;
    else if (w_hit[3]) w_sel = 4'b1000;
  end

  // Pick the read data of the slave currently selected.
  always_comb begin
    w_sel_rdata = 32'h0;
    case (r_sel)
      4'b0001: w_sel_rdata = i_s_rdata0;
      4'b0010: w_sel_rdata = i_s_rdata1;
      4'b0100: w_sel_rdata = i_s_rdata2;
      4'b1000: w_sel_rdata = i_s_rdata3;
      default: w_sel_rdata = 32'h0;
    endcase
  end

  assign w_accept    = (r_state == IDLE) && i_m_valid;
  assign w_sel_ready = (r_state == REQ) && |(i_s_ready & r_sel);
  assign w_timeout   = (r_state == REQ) && (r_cnt == TMO_LAST);

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; a slave handshake outranks an expiring timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (i_m_valid) w_state_nxt = (|w_sel) ? REQ : ERR;
      end
      REQ: begin
        if (w_sel_ready)    w_state_nxt = RESP;
        else if (w_timeout) w_state_nxt = ERR;
      end
      RESP:    w_state_nxt = IDLE;
      ERR:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latch the request payload and slave select when a new request is accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_accept) begin
      r_sel   <= w_sel;
      r_addr  <= i_m_addr;
      r_we    <= i_m_we;
      r_wdata <= i_m_wdata;
      r_be    <= i_m_be;
    end
  end

  // Stall counter runs only while a request is outstanding and restarts on completion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                  r_cnt <= '0;
    else if ((r_state == REQ) && !w_sel_ready && !w_timeout) r_cnt <= r_cnt + 8'd1;
    else                                           r_cnt <= '0;
  end

  // Registered completion: one-cycle pulse, data only on a successful read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_m_ready <= 1'b0;
      r_m_err   <= 1'b0;
      r_m_rdata <= '0;
    end else begin
      r_m_ready <= (w_state_nxt == RESP) || (w_state_nxt == ERR);
      r_m_err   <= (w_state_nxt == ERR);
      r_m_rdata <= (w_sel_ready && !r_we) ? w_sel_rdata : 32'h0;
    end
  end

  assign o_m_ready = r_m_ready;
  assign o_m_err   = r_m_err;
  assign o_m_rdata = r_m_rdata;
  // Request strobe comes straight from the state register so reset clears it at once.
  assign o_s_valid = (r_state == REQ) ? r_sel : 4'b0000;
  assign o_s_addr  = r_addr;
  assign o_s_we    = r_we;
  assign o_s_wdata = r_wdata;
  assign o_s_be    = r_be;

endmodule

// File: doc/data_bus_router.md
# data_bus_router

Single-master to four-slave data-bus router for the RV32I core's load/store port. It decodes each request address against four programmable regions and forwards the request to exactly one slave. It waits for that slave's handshake, registers the read data back to the core, and returns an error for unmapped addresses or slaves that stall too long. It is the distribution side of the core's read-data 4:1 selection path.

## Interface
- BASE0, 32'h0000_0000: region 0 base address
- BASE1, 32'h1000_0000: region 1 base address
- BASE2, 32'h2000_0000: region 2 base address
- BASE3, 32'h4000_0000: region 3 base address
- MASK, 32'hF000_0000: compare mask, common to all regions; region i hits when (ADDR & MASK) == (BASEi & MASK)
- TIMEOUT, 8'd255: maximum cycles a slave may hold off S_READY (1..255)

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- M_VALID  in  1  master request valid
- M_ADDR  in  32  request byte address
- M_WE  in  1  1 = write, 0 = read
- M_WDATA  in  32  write data
- M_BE  in  4  byte enables
- M_READY  out  1  one-cycle completion pulse
- M_RDATA  out  32  registered read data, valid while M_READY = 1
- M_ERR  out  1  error flag, valid while M_READY = 1
- S_VALID  out  4  one-hot request to slave i
- S_ADDR  out  32  latched address, shared by all slaves
- S_WE  out  1  latched write enable, shared
- S_WDATA  out  32  latched write data, shared
- S_BE  out  4  latched byte enables, shared
- S_READY  in  4  slave i accepts/completes the request
- S_RDATA0..S_RDATA3  in  32 each  slave read data, sampled with S_READY[i]

## Operation
- FSM states: IDLE, REQ, RESP, ERR.
- **IDLE**
  - When M_VALID = 1: latch ADDR/WE/WDATA/BE, decode, store the one-hot select.
  - Go to REQ on a hit, ERR on no hit.
- **Overlapping regions:** the lowest index wins.
- **REQ**
  - S_VALID[sel] = 1; other S_VALID bits stay 0.
  - The timeout counter increments each cycle.
  - When S_READY[sel] = 1 is sampled: capture S_RDATA_sel (0 for writes), clear the counter, go to RESP.
  - S_READY bits of unselected slaves are ignored.
  - When the counter reaches TIMEOUT with no S_READY: drop S_VALID, go to ERR.
- **RESP:** M_READY = 1, M_ERR = 0, M_RDATA = captured data; go to IDLE.
- **ERR:** M_READY = 1, M_ERR = 1, M_RDATA = 0; go to IDLE.
- **Master obligations:** hold M_VALID and payload stable until M_READY. M_VALID seen in IDLE the cycle after M_READY starts a new transaction (back-to-back allowed).
- **Latched outputs:** S_ADDR/S_WE/S_WDATA/S_BE hold the latched values outside REQ. Slaves must qualify them with S_VALID.

## Timing
- **Reset:** all outputs 0, state IDLE, counter 0, latches 0.
- **Reset assertion mid-transaction:** immediately aborts, S_VALID drops to 0 asynchronously; no response is issued.
- **Mapped access, zero-wait slave:** M_VALID at cycle 0, S_VALID at cycle 1, M_READY at cycle 2.
- **Mapped access, slave waits:** each slave wait cycle adds one cycle.
- **Unmapped access:** M_VALID at cycle 0, M_READY with M_ERR at cycle 1.
- **Timeout:** S_VALID is high for exactly TIMEOUT cycles, then M_READY with M_ERR follows one cycle later.
- **Simultaneous S_READY and counter = TIMEOUT:** S_READY wins (normal response).
- **Output registering:** M_READY, M_ERR and M_RDATA are registered; M_READY never lasts more than one cycle.

## Test plan
- **Zero-wait read:** read 0x1000_0010, S_READY[1] = 1 immediately, S_RDATA1 = 32'hCAFE_0001 → S_VALID = 4'b0010 at cycle 1; M_READY = 1, M_RDATA = 32'hCAFE_0001, M_ERR = 0 at cycle 2.
- **Waited write:** write 0x4000_0004, WDATA 32'h1234_5678, BE 4'b0011, slave 3 waits 3 cycles → S_VALID[3] high 4 cycles with stable S_WDATA/S_BE; M_READY at cycle 5, M_RDATA = 0.
- **Unmapped read:** read 0x8000_0000 → S_VALID never asserted; M_READY = 1, M_ERR = 1 at cycle 1.
- **Timeout:** TIMEOUT = 4, slave 0 never ready → S_VALID[0] high exactly 4 cycles, then M_ERR pulse; S_READY[0] arriving on the 4th cycle gives a normal response instead.
- **Back-to-back:** region 2 read then region 0 read with M_VALID held continuously → two M_READY pulses 3 cycles apart, correct data each; S_READY on a non-selected slave has no effect.
- **Reset in REQ:** RST_N low during a stalled request → S_VALID = 0 immediately; after release, a fresh read completes normally.
